// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word-wide data memory with configurable access
// latency, upstream freeze while an access is in flight, registered MEM/WB bundle.
module mem_stage #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] ALU_result,
    input  logic [31:0] val_src2,
    input  logic [4:0]  dest,
    input  logic        WB_EN,
    input  logic        MEM_Read,
    input  logic        MEM_Write,
    output logic        freeze,
    output logic        wb_valid,
    output logic        WB_EN_out,
    output logic        MEM_Read_out,
    output logic [31:0] ALU_result_out,
    output logic [31:0] mem_data_out,
    output logic [4:0]  dest_out
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (MEM_LATENCY > 0) ? CNT_W'(MEM_LATENCY - 1) : '0;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [31:0]       r_mem [DEPTH];
    logic              w_mem_op;
    logic              w_freeze;
    logic              w_complete;
    logic [IDX_W-1:0]  w_idx;

    assign w_mem_op = valid_in & (MEM_Read | MEM_Write);
    assign w_idx    = ALU_result[IDX_W+1:2];
    // Freeze must drop the instant reset is asserted, even mid-access.
    assign freeze   = w_freeze & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_freeze    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_op && (MEM_LATENCY > 0)) begin
                    w_freeze    = 1'b1;
                    w_cnt_nxt   = CNT_INIT;
                    w_state_nxt = WAIT;
                end else begin
                    w_complete  = 1'b1;
                end
            end
            WAIT: begin
                if (r_cnt != '0) begin
                    w_freeze  = 1'b1;
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Contents survive reset; a reset edge never commits a store.
    always_ff @(posedge clk) begin
        if (rst && w_complete && valid_in && MEM_Write)
            r_mem[w_idx] <= val_src2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid       <= 1'b0;
            WB_EN_out      <= 1'b0;
            MEM_Read_out   <= 1'b0;
            ALU_result_out <= '0;
            mem_data_out   <= '0;
            dest_out       <= '0;
        end else if (w_complete) begin
            wb_valid       <= valid_in;
            WB_EN_out      <= WB_EN & valid_in;
            MEM_Read_out   <= MEM_Read & valid_in & ~MEM_Write;
            ALU_result_out <= ALU_result;
            dest_out       <= dest;
            if (valid_in && MEM_Read && !MEM_Write)
                mem_data_out <= r_mem[w_idx];
            else
                mem_data_out <= '0;
        end else begin
            wb_valid     <= 1'b0;
            WB_EN_out    <= 1'b0;
            MEM_Read_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: latency-2 and latency-0 instances share clock and reset;
// drivers push expected MEM/WB bundles, negedge monitors pop and compare.
module tb_mem_stage;

    typedef struct packed {
        logic        wb_en;
        logic        mrd;
        logic [31:0] alu;
        logic [31:0] data;
        logic [4:0]  dest;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        v2 = 0, rd2 = 0, wr2 = 0, wb2 = 0;
    logic [31:0] alu2 = '0, sd2 = '0;
    logic [4:0]  d2 = '0;
    logic        f2, wv2, wbo2, rdo2;
    logic [31:0] alo2, mdo2;
    logic [4:0]  do2;

    logic        v0 = 0, rd0 = 0, wr0 = 0, wb0 = 0;
    logic [31:0] alu0 = '0, sd0 = '0;
    logic [4:0]  d0 = '0;
    logic        f0, wv0, wbo0, rdo0;
    logic [31:0] alo0, mdo0;
    logic [4:0]  do0;

    mem_stage #(.DEPTH(64), .MEM_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .valid_in(v2), .ALU_result(alu2), .val_src2(sd2),
        .dest(d2), .WB_EN(wb2), .MEM_Read(rd2), .MEM_Write(wr2), .freeze(f2),
        .wb_valid(wv2), .WB_EN_out(wbo2), .MEM_Read_out(rdo2),
        .ALU_result_out(alo2), .mem_data_out(mdo2), .dest_out(do2)
    );

    mem_stage #(.DEPTH(64), .MEM_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .valid_in(v0), .ALU_result(alu0), .val_src2(sd0),
        .dest(d0), .WB_EN(wb0), .MEM_Read(rd0), .MEM_Write(wr0), .freeze(f0),
        .wb_valid(wv0), .WB_EN_out(wbo0), .MEM_Read_out(rdo0),
        .ALU_result_out(alo0), .mem_data_out(mdo0), .dest_out(do0)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q2[$];
    exp_t q0[$];
    exp_t m2, m0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (wv2) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL wb2_unexpected: got wb_valid=1 expected 0 at %0t", $time);
            end else begin
                m2 = q2.pop_front();
                chk("wb2_bundle", 80'({wbo2, rdo2, alo2, mdo2, do2}), 80'(m2));
            end
        end
        if (wv0) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL wb0_unexpected: got wb_valid=1 expected 0 at %0t", $time);
            end else begin
                m0 = q0.pop_front();
                chk("wb0_bundle", 80'({wbo0, rdo0, alo0, mdo0, do0}), 80'(m0));
            end
        end
    end

    // Issue one op on the latency-2 instance; called just after a rising edge.
    task automatic op2(input logic rd, input logic wr, input logic wb, input logic [4:0] d,
                       input logic [31:0] a, input logic [31:0] s, input exp_t e,
                       input int exp_frz);
        int n;
        n = 0;
        v2 = 1; rd2 = rd; wr2 = wr; wb2 = wb; d2 = d; alu2 = a; sd2 = s;
        q2.push_back(e);
        #1;
        while (f2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("freeze_cycles2", 80'(n), 80'(exp_frz));
        @(posedge clk); #1;
        chk("wb_valid_timing2", 80'(wv2), 80'(1));
        v2 = 0; rd2 = 0; wr2 = 0; wb2 = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic        t_rd [5];
        logic        t_wr [5];
        logic [31:0] t_a  [5];
        logic [31:0] t_s  [5];
        logic [4:0]  t_d  [5];
        logic [31:0] t_x  [5];

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs2", 80'({f2, wv2, wbo2, rdo2, alo2, mdo2, do2}), 80'(0));
        chk("reset_outs0", 80'({f0, wv0, wbo0, rdo0, alo0, mdo0, do0}), 80'(0));
        @(negedge clk) rst = 1;
        @(posedge clk); #1;

        op2(0, 0, 1, 5'd5, 32'h1234, 32'h0, '{1'b1, 1'b0, 32'h1234, 32'h0, 5'd5}, 0);
        op2(0, 1, 0, 5'd0, 32'h08, 32'hDEADBEEF, '{1'b0, 1'b0, 32'h08, 32'h0, 5'd0}, 2);
        op2(1, 0, 1, 5'd3, 32'h08, 32'h0, '{1'b1, 1'b1, 32'h08, 32'hDEADBEEF, 5'd3}, 2);

        op2(0, 1, 0, 5'd0, 32'h100, 32'h55, '{1'b0, 1'b0, 32'h100, 32'h0, 5'd0}, 2);
        op2(1, 0, 1, 5'd4, 32'h000, 32'h0, '{1'b1, 1'b1, 32'h000, 32'h55, 5'd4}, 2);
        op2(1, 0, 1, 5'd6, 32'h103, 32'h0, '{1'b1, 1'b1, 32'h103, 32'h55, 5'd6}, 2);

        op2(1, 1, 1, 5'd7, 32'h0C, 32'hA5, '{1'b1, 1'b0, 32'h0C, 32'h0, 5'd7}, 2);
        op2(1, 0, 1, 5'd8, 32'h0C, 32'h0, '{1'b1, 1'b1, 32'h0C, 32'hA5, 5'd8}, 2);

        // Reset in the middle of a store: the store must be lost.
        op2(0, 1, 0, 5'd0, 32'h28, 32'h11111111, '{1'b0, 1'b0, 32'h28, 32'h0, 5'd0}, 2);
        v2 = 1; wr2 = 1; alu2 = 32'h28; sd2 = 32'h22222222;
        @(posedge clk); #1;
        chk("freeze_in_wait", 80'(f2), 80'(1));
        rst = 0;
        #1;
        chk("midwait_reset_outs", 80'({f2, wv2, wbo2, rdo2, alo2, mdo2, do2}), 80'(0));
        v2 = 0; wr2 = 0;
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
        op2(1, 0, 1, 5'd9, 32'h28, 32'h0, '{1'b1, 1'b1, 32'h28, 32'h11111111, 5'd9}, 2);

        // Latency 0: alternating stores and loads, one per cycle.
        t_rd = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        t_wr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        t_a  = '{32'h14, 32'h14, 32'h18, 32'h18, 32'h14};
        t_s  = '{32'hAAAA0001, 32'h0, 32'hBBBB0002, 32'h0, 32'h0};
        t_d  = '{5'd0, 5'd9, 5'd0, 5'd10, 5'd11};
        t_x  = '{32'h0, 32'hAAAA0001, 32'h0, 32'hBBBB0002, 32'hAAAA0001};
        for (int i = 0; i < 5; i++) begin
            v0 = 1; rd0 = t_rd[i]; wr0 = t_wr[i]; wb0 = t_rd[i];
            alu0 = t_a[i]; sd0 = t_s[i]; d0 = t_d[i];
            q0.push_back('{t_rd[i], t_rd[i], t_a[i], t_x[i], t_d[i]});
            #1;
            chk("freeze0_low", 80'(f0), 80'(0));
            @(posedge clk); #1;
        end
        v0 = 0; rd0 = 0; wr0 = 0; wb0 = 0;

        repeat (4) @(posedge clk);
        #1;
        chk("q2_drained", 80'(q2.size()), 80'(0));
        chk("q0_drained", 80'(q0.size()), 80'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
